// File: rtl/tl_pkg.sv
// Shared traffic-light definitions: controller state encoding and per-phase lamp patterns.
package tl_pkg;

  typedef enum logic [1:0] {
    ST_START  = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_ALLRED = 2'd3
  } tl_state_e;

  // Lamp patterns are {red, yellow, green}
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  function automatic logic [2:0] lamp_of(input tl_state_e st, input logic owner);
    if (owner && st == ST_GREEN)  return LAMP_GREEN;
    if (owner && st == ST_YELLOW) return LAMP_YELLOW;
    return LAMP_RED;
  endfunction

endpackage

// File: rtl/tl_tickgen.sv
// Timing-tick prescaler: free-running 0..TICK_DIV-1 counter, o_tick high on the last count.
module tl_tickgen #(
  parameter int TICK_DIV = 5000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam int             CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign o_tick = (cnt_q == LAST);
  assign cnt_d  = o_tick ? '0 : cnt_q + CW'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tlctrl_np.sv
// N-phase traffic controller: tick-timed START/GREEN/YELLOW/ALLRED sequencing with
// optional demand-driven phase skipping. Lamps are registered from the next state.
module tlctrl_np
  import tl_pkg::*;
#(
  parameter int N_PHASES    = 2,
  parameter int T_WIDTH     = 12,
  parameter int TICK_DIV    = 5000000,
  parameter int START_TIME  = 30,
  parameter int YELLOW_TIME = 30,
  parameter int ALLRED_TIME = 10,
  parameter int SKIP_EN     = 0
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [N_PHASES*T_WIDTH-1:0]   i_green_time,
  input  logic [N_PHASES-1:0]           i_req,
  output logic [N_PHASES-1:0]           o_red,
  output logic [N_PHASES-1:0]           o_yellow,
  output logic [N_PHASES-1:0]           o_green,
  output logic [$clog2(N_PHASES)-1:0]   o_phase,
  output logic                          o_tick
);

  localparam int PW = $clog2(N_PHASES);

  // A duration of D ticks loads D-1; zero is stretched to one tick.
  function automatic logic [T_WIDTH-1:0] dur_m1(input int d);
    return (d <= 1) ? '0 : T_WIDTH'(d - 1);
  endfunction

  function automatic logic [PW-1:0] first_phase(input logic [N_PHASES-1:0] pend);
    logic [PW-1:0] nxt;
    nxt = '0;
    if (SKIP_EN != 0)
      for (int i = N_PHASES - 1; i >= 0; i--)
        if (pend[i]) nxt = PW'(i);
    return nxt;
  endfunction

  function automatic logic [PW-1:0] next_phase(input logic [PW-1:0] cur,
                                               input logic [N_PHASES-1:0] pend);
    logic [PW-1:0] nxt;
    logic          found;
    int            idx;
    idx   = (int'(cur) + 1) % N_PHASES;
    nxt   = PW'(idx);
    found = 1'b0;
    if (SKIP_EN != 0)
      for (int i = 1; i < N_PHASES; i++) begin
        idx = (int'(cur) + i) % N_PHASES;
        if (!found && pend[idx]) begin
          nxt   = PW'(idx);
          found = 1'b1;
        end
      end
    return nxt;
  endfunction

  logic                  tick;
  tl_state_e             state_q, state_d;
  logic [T_WIDTH-1:0]    timer_q, timer_d, green_dur;
  logic [PW-1:0]         phase_q, phase_d;
  logic [N_PHASES-1:0]   pend_q, pend_d, clr;
  logic [N_PHASES-1:0]   red_q, red_d, yel_q, yel_d, grn_q, grn_d;
  logic                  enter_green, others;

  tl_tickgen #(.TICK_DIV(TICK_DIV)) u_tickgen (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_tick  (tick)
  );

  always_comb begin
    others = 1'b0;
    for (int k = 0; k < N_PHASES; k++)
      if (pend_q[k] && phase_q != PW'(k)) others = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    phase_d     = phase_q;
    enter_green = 1'b0;
    if (tick) begin
      if (timer_q != '0) timer_d = timer_q - 1'b1;
      else begin
        case (state_q)
          ST_START:  begin phase_d = first_phase(pend_q); enter_green = 1'b1; end
          ST_GREEN:  if (SKIP_EN == 0 || others) begin
                       state_d = ST_YELLOW;
                       timer_d = dur_m1(YELLOW_TIME);
                     end
          ST_YELLOW: begin state_d = ST_ALLRED; timer_d = dur_m1(ALLRED_TIME); end
          ST_ALLRED: begin phase_d = next_phase(phase_q, pend_q); enter_green = 1'b1; end
          default:   ;
        endcase
      end
    end
    // Green length is captured only at entry; later edits wait for the next entry.
    green_dur = i_green_time[int'(phase_d)*T_WIDTH +: T_WIDTH];
    if (enter_green) begin
      state_d = ST_GREEN;
      timer_d = (green_dur == '0) ? '0 : green_dur - 1'b1;
    end
    for (int k = 0; k < N_PHASES; k++) clr[k] = enter_green && (phase_d == PW'(k));
    // A request arriving in the clearing cycle keeps the phase pending.
    pend_d = i_req | (pend_q & ~clr);
  end

  for (genvar k = 0; k < N_PHASES; k++) begin : g_lamp
    assign {red_d[k], yel_d[k], grn_d[k]} = lamp_of(state_d, phase_d == PW'(k));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_START;
      timer_q <= dur_m1(START_TIME);
      phase_q <= '0;
      pend_q  <= '0;
      red_q   <= '1;
      yel_q   <= '0;
      grn_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      phase_q <= phase_d;
      pend_q  <= pend_d;
      red_q   <= red_d;
      yel_q   <= yel_d;
      grn_q   <= grn_d;
    end
  end

  assign o_red    = red_q;
  assign o_yellow = yel_q;
  assign o_green  = grn_q;
  assign o_phase  = phase_q;
  assign o_tick   = tick;

endmodule

// File: tb/tb_tlctrl_np.sv
// Directed bench: fixed-order timeline, async reset mid-yellow, demand skipping, 8-phase service order.
module tb_tlctrl_np;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic        rst0, rst1, rst2;
  logic [35:0] gt0, gt1;
  logic [95:0] gt2;
  logic [2:0]  req0, req1;
  logic [7:0]  req2;
  logic [2:0]  red0, yel0, grn0, red1, yel1, grn1;
  logic [7:0]  red2, yel2, grn2;
  logic [1:0]  ph0, ph1;
  logic [2:0]  ph2;
  logic        tick0, tick1, tick2;

  tlctrl_np #(.N_PHASES(3), .T_WIDTH(12), .TICK_DIV(4), .START_TIME(3), .YELLOW_TIME(2),
              .ALLRED_TIME(1), .SKIP_EN(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst0), .i_green_time(gt0), .i_req(req0),
    .o_red(red0), .o_yellow(yel0), .o_green(grn0), .o_phase(ph0), .o_tick(tick0));

  tlctrl_np #(.N_PHASES(3), .T_WIDTH(12), .TICK_DIV(4), .START_TIME(3), .YELLOW_TIME(2),
              .ALLRED_TIME(1), .SKIP_EN(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst1), .i_green_time(gt1), .i_req(req1),
    .o_red(red1), .o_yellow(yel1), .o_green(grn1), .o_phase(ph1), .o_tick(tick1));

  tlctrl_np #(.N_PHASES(8), .T_WIDTH(12), .TICK_DIV(2), .START_TIME(3), .YELLOW_TIME(2),
              .ALLRED_TIME(1), .SKIP_EN(1)) dut2 (
    .i_clk(clk), .i_rst_n(rst2), .i_green_time(gt2), .i_req(req2),
    .o_red(red2), .o_yellow(yel2), .o_green(grn2), .o_phase(ph2), .o_tick(tick2));

  // st: 0 = all red, 1 = green, 2 = yellow; ph = expected o_phase
  typedef struct { int k0; int k1; int st; int ph; } seg_t;
  seg_t segs[14];
  seg_t pts1[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [8:0] exp3(input int st, input int ph);
    logic [2:0] one, g, y, r;
    one = 3'b001 << ph;
    g   = (st == 1) ? one : 3'b000;
    y   = (st == 2) ? one : 3'b000;
    r   = ~(g | y);
    return {r, y, g};
  endfunction

  task automatic inv(input string nm, input logic [7:0] r, input logic [7:0] y,
                     input logic [7:0] g, input int n);
    logic ok;
    int   nonred;
    ok = 1'b1;
    nonred = 0;
    for (int k = 0; k < n; k++) begin
      if (int'(r[k]) + int'(y[k]) + int'(g[k]) != 1) ok = 1'b0;
      if (!r[k]) nonred++;
    end
    chk(nm, {30'd0, ok, nonred <= 1}, 32'd3);
  endtask

  task automatic run_dut0(input int kmax, input bit mod_gt);
    int st, ph;
    for (int k = 0; k <= kmax; k++) begin
      if (k > 0) @(negedge clk);
      if (mod_gt && k == 20) gt0 = {12'd0, 12'd4, 12'd2};
      st = -1; ph = 0;
      foreach (segs[i]) if (k >= segs[i].k0 && k <= segs[i].k1) begin st = segs[i].st; ph = segs[i].ph; end
      chk($sformatf("d0 lamps k=%0d", k), {21'd0, red0, yel0, grn0, ph0}, {21'd0, exp3(st, ph), 2'(ph)});
      chk($sformatf("d0 tick k=%0d", k), {31'd0, tick0}, {31'd0, (k % 4) == 3});
      inv($sformatf("d0 invariant k=%0d", k), {5'd0, red0}, {5'd0, yel0}, {5'd0, grn0}, 3);
    end
  endtask

  initial begin
    int     seen[$];
    logic   prev_g;
    bit     done;
    segs[0]  = '{0,   11,  0, 0};
    segs[1]  = '{12,  31,  1, 0};
    segs[2]  = '{32,  39,  2, 0};
    segs[3]  = '{40,  43,  0, 0};
    segs[4]  = '{44,  59,  1, 1};
    segs[5]  = '{60,  67,  2, 1};
    segs[6]  = '{68,  71,  0, 1};
    segs[7]  = '{72,  75,  1, 2};
    segs[8]  = '{76,  83,  2, 2};
    segs[9]  = '{84,  87,  0, 2};
    segs[10] = '{88,  95,  1, 0};
    segs[11] = '{96,  103, 2, 0};
    segs[12] = '{104, 107, 0, 0};
    segs[13] = '{108, 123, 1, 1};
    pts1[0] = '{11, 11, 0, 0};
    pts1[1] = '{12, 12, 1, 0};
    pts1[2] = '{31, 31, 1, 0};
    pts1[3] = '{60, 60, 1, 0};
    pts1[4] = '{63, 63, 1, 0};
    pts1[5] = '{64, 64, 2, 0};
    pts1[6] = '{72, 72, 0, 0};
    pts1[7] = '{76, 76, 1, 2};
    pts1[8] = '{100, 100, 1, 2};

    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    gt0 = {12'd3, 12'd4, 12'd5};
    gt1 = {12'd3, 12'd4, 12'd5};
    gt2 = {8{12'd1}};
    req0 = '0; req1 = '0; req2 = '1;
    #2;
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset lamps", {21'd0, red0, yel0, grn0, ph0}, {21'd0, 3'b111, 3'b000, 3'b000, 2'd0});
    chk("reset tick", {31'd0, tick0}, 32'd0);

    // Fixed-order run, interrupted by an asynchronous reset during phase 1 yellow
    @(negedge clk); rst0 = 1'b1; #1;
    run_dut0(62, 1'b0);
    #3 rst0 = 1'b0;
    #1;
    chk("async reset lamps", {21'd0, red0, yel0, grn0, ph0}, {21'd0, 3'b111, 3'b000, 3'b000, 2'd0});
    chk("async reset tick", {31'd0, tick0}, 32'd0);
    repeat (2) @(negedge clk);
    chk("held reset", {20'd0, red0, yel0, grn0, ph0, tick0}, {20'd0, 3'b111, 3'b000, 3'b000, 2'd0, 1'b0});

    // Restart: full cycle with wrap, plus green-time edits mid-green
    @(negedge clk); rst0 = 1'b1; #1;
    run_dut0(123, 1'b1);

    // Demand-skipping controller
    @(negedge clk); rst1 = 1'b1; #1;
    for (int k = 0; k <= 100; k++) begin
      if (k > 0) @(negedge clk);
      foreach (pts1[i]) if (k == pts1[i].k0)
        chk($sformatf("d1 lamps k=%0d", k), {21'd0, red1, yel1, grn1, ph1},
            {21'd0, exp3(pts1[i].st, pts1[i].ph), 2'(pts1[i].ph)});
      if (k == 62) chk("d1 pending set", {29'd0, dut1.pend_q}, 32'd4);
      if (k == 77) chk("d1 pending cleared", {29'd0, dut1.pend_q}, 32'd0);
      inv($sformatf("d1 invariant k=%0d", k), {5'd0, red1}, {5'd0, yel1}, {5'd0, grn1}, 3);
      if (k == 61) req1 = 3'b100;
      if (k == 62) req1 = 3'b000;
    end

    // Eight phases, all demanding: every phase served in order
    @(negedge clk); rst2 = 1'b1; #1;
    prev_g = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      inv($sformatf("d2 invariant c=%0d", c), red2, yel2, grn2, 8);
      if (grn2 != 8'd0 && !prev_g) begin
        seen.push_back(int'(ph2));
        chk($sformatf("d2 green owner c=%0d", c), {24'd0, grn2}, {24'd0, 8'd1 << ph2});
        if (seen.size() == 9) done = 1'b1;
      end
      prev_g = (grn2 != 8'd0);
    end
    chk("d2 completed within budget", {31'd0, done}, 32'd1);
    foreach (seen[i]) chk($sformatf("d2 order %0d", i), seen[i], i % 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tlctrl_np.md
TLCTRL_NP -- requirements
Module: tlctrl_np

Interface
REQ-001 Parameter N_PHASES, default 2, number of signal phases (legal 2..8).
REQ-002 Parameter T_WIDTH, default 12, width of every tick timer/duration field.
REQ-003 Parameter TICK_DIV, default 5000000, i_clk cycles per timing tick (legal >= 2).
REQ-004 Parameter START_TIME, default 30, all-red ticks after reset.
REQ-005 Parameter YELLOW_TIME, default 30, yellow ticks; ALLRED_TIME, default 10, all-red clearance ticks.
REQ-006 Parameter SKIP_EN, default 0; 1 = serve only phases with pending demand.
REQ-007 i_clk  input  1  single system clock.
REQ-008 i_rst_n  input  1  reset; asynchronous, active-low.
REQ-009 i_green_time  input  N_PHASES*T_WIDTH  per-phase green duration in ticks, phase k at bits [k*T_WIDTH +: T_WIDTH].
REQ-010 i_req  input  N_PHASES  per-phase demand (detector/pedestrian), level or pulse, synchronous to i_clk.
REQ-011 o_red, o_yellow, o_green  output  N_PHASES each  per-phase lamp drives, registered.
REQ-012 o_phase  output  clog2(N_PHASES)  index of phase currently owning right-of-way.
REQ-013 o_tick  output  1  one-cycle pulse per timing tick.

Function
REQ-014 Prescaler counts 0..TICK_DIV-1 on i_clk, wraps; o_tick=1 in the cycle count==TICK_DIV-1.
REQ-015 FSM states: START, GREEN, YELLOW, ALLRED; all state changes occur only in o_tick cycles.
REQ-016 On state entry, timer loads duration-1; decrements on each tick; exit on tick with timer==0, so a state of duration D lasts exactly D ticks; duration 0 treated as 1.
REQ-017 START -> GREEN of first served phase (phase 0 if SKIP_EN=0, else lowest-index pending phase, else phase 0).
REQ-018 GREEN duration = i_green_time of current phase, sampled once at GREEN entry; mid-green changes take effect next entry.
REQ-019 GREEN -> YELLOW at expiry if SKIP_EN=0, or if SKIP_EN=1 and any other phase pending; otherwise rest in green, re-evaluated each tick.
REQ-020 YELLOW -> ALLRED after YELLOW_TIME; ALLRED -> GREEN of next phase after ALLRED_TIME.
REQ-021 Next phase: SKIP_EN=0 -> (o_phase+1) mod N_PHASES; SKIP_EN=1 -> first pending phase searching cyclically from o_phase+1, excluding o_phase.
REQ-022 pending[k] set on any cycle i_req[k]=1; cleared in the cycle phase k enters GREEN; set-and-clear same cycle -> clear wins only if i_req[k]=0 that cycle, else stays set.
REQ-023 Lamp map: GREEN -> o_green[o_phase]=1; YELLOW -> o_yellow[o_phase]=1; all other phases red; START/ALLRED -> all red.
REQ-024 Invariant: per phase exactly one lamp bit set; at most one phase non-red; outputs change only the cycle after a state change (1-cycle registered latency).
REQ-025 o_phase updates on GREEN entry and holds through YELLOW and ALLRED.

Reset
REQ-026 Asserting i_rst_n=0 at any time, including mid-state, immediately forces: state START, prescaler 0, timer START_TIME-1, pending 0, o_phase 0, o_red all 1, o_yellow 0, o_green 0, o_tick 0.
REQ-027 After deassertion, first o_tick occurs TICK_DIV cycles later; START lasts START_TIME ticks.

Structure
REQ-028 Shared package tl_pkg holds the state enumeration and lamp-pattern constants for reuse by other traffic blocks.
REQ-029 Prescaler is a sub-module tl_tickgen (parameter TICK_DIV, ports i_clk, i_rst_n, o_tick); FSM, timer, pending logic live in tlctrl_np.

Verification
Bench parameters unless stated: N_PHASES=3, TICK_DIV=4, START_TIME=3, YELLOW_TIME=2, ALLRED_TIME=1, green times 5/4/3.
REQ-030 Reset release, SKIP_EN=0 -> all red 12 cycles, then phase 0 green 20 cycles, yellow 8, all-red 4, phase 1 green 16; o_tick every 4 cycles.
REQ-031 SKIP_EN=0 full cycle -> order 0,1,2,0; o_phase wraps 2->0; invariant REQ-024 checked every cycle.
REQ-032 SKIP_EN=1, no requests -> phase 0 rests in green indefinitely; pulse i_req[2] one cycle -> yellow at next tick, then phase 2 green (phase 1 skipped), pending[2] cleared.
REQ-033 Change i_green_time[0] from 5 to 2 mid-green -> current green still 5 ticks; next phase-0 green 2 ticks; green time 0 -> 1 tick.
REQ-034 Assert i_rst_n=0 mid-yellow of phase 1 -> outputs all red, o_phase 0 asynchronously; sequence restarts per REQ-030.
REQ-035 TICK_DIV=2, N_PHASES=8, SKIP_EN=1, i_req held all ones -> every phase served in order 0..7, none skipped.
